inst_fetch_unit: RTL

//  Requesting side of the instruction-memory read interface: owns the PC, drives instRead/instAddress

---
 rtl/inst_fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues reads to instruction memory and buffers
// returned words with their PCs in a small FIFO toward decode.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchEn,
  output logic        instRead,
  output logic [31:0] instAddress,
  input  logic [31:0] InstRead,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        instValid,
  output logic [31:0] instOut,
  output logic [31:0] instPC,
  input  logic        instReady,
  output logic        fetchFault,
  output logic [31:0] fetchCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [31:0]      pc;
  logic [31:0]      instBuf [FIFO_DEPTH];
  logic [31:0]      pcBuf   [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             push;

  assign full        = (count == DEPTH_C);
  assign instValid   = (count != {(PTR_W + 1){1'b0}});
  assign pop         = instValid && instReady;
  assign push        = instRead;
  assign instAddress = pc;
  // Head slots are registers, so these hold the last-read values when empty.
  assign instOut     = instBuf[rdPtr];
  assign instPC      = pcBuf[rdPtr];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and read-strobe decode; a redirect cycle never issues a read
  always_comb begin
    nextState = state;
    instRead  = 1'b0;
    case (state)
      IDLE: begin
        if (fetchEn) begin
          nextState = RUN;
        end else begin
          nextState = IDLE;
        end
      end
      RUN: begin
        instRead = !branchTaken && (!full || pop);
        if (!fetchEn) begin
          nextState = IDLE;
        end else begin
          nextState = RUN;
        end
      end
      default: begin
        nextState = IDLE;
        instRead  = 1'b0;
      end
    endcase
  end

  // PC, FIFO storage/pointers and fetch counter; redirect flushes ahead of push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= {RESET_PC[31:2], 2'b00};
      rdPtr      <= {PTR_W{1'b0}};
      wrPtr      <= {PTR_W{1'b0}};
      count      <= {(PTR_W + 1){1'b0}};
      fetchCount <= 32'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instBuf[i] <= 32'd0;
        pcBuf[i]   <= 32'd0;
      end
    end else if (branchTaken) begin
      pc    <= {branchTarget[31:2], 2'b00};
      rdPtr <= {PTR_W{1'b0}};
      wrPtr <= {PTR_W{1'b0}};
      count <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push) begin
        instBuf[wrPtr] <= InstRead;
        pcBuf[wrPtr]   <= pc;
        wrPtr          <= wrPtr + PTR_W'(1);
        pc             <= pc + 32'd4;
        fetchCount     <= fetchCount + 32'd1;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W + 1)'(1);
      end else begin
        count <= count;
      end
    end
  end

  // Misaligned redirect target flag, high for the cycle after the redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchFault <= 1'b0;
    end else begin
      fetchFault <= branchTaken && (branchTarget[1:0] != 2'b00);
    end
  end

endmodule
